lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Synthesizable responder for the HD44780-style 4-bit LCD bus: the LCD end of the interface our LCD control FSM drives.
- Samples E/RS/RW/DB[3:0], tracks the power-on 8-bit-to-4-bit handshake, assembles nibble pairs into bytes and decodes command class.
- Models busy time and the DDRAM address counter, and answers busy-flag reads.
- Used as a bench/loopback target for LCD controllers and as an on-chip protocol checker.

Parameters:
- BUSY_CYCLES, 2: busy duration after an ordinary command, data write or power-up nibble.
- CLEAR_BUSY_CYCLES, 82: busy duration after Clear Display or Return Home.
- MIN_INIT_NIBBLES, 3: number of 0x3 nibbles required before the 0x2 nibble is legal.

Ports:
- Clock in 1: single clock; all logic on its rising edge.
- Reset in 1: asynchronous, active-low reset.
- iLCD_Enabled in 1: LCD E strobe.
- iLCD_RegisterSelect in 1: 0 = command, 1 = data.
- iLCD_ReadWrite in 1: 0 = write, 1 = read.
- iLCD_Data in 4: DB[7:4] nibble.
- oByte out 8: last assembled byte.
- oIsData out 1: RS of oByte.
- oCmdClass out 3: decoded command class of oByte.
- oByteValid out 1: one-cycle pulse when oByte/oIsData/oCmdClass update.
- oFourBitMode out 1: 4-bit mode entered.
- oInitDone out 1: Clear Display received in 4-bit mode; sticky.
- oBusy out 1: busy counter nonzero.
- oAddress out 7: DDRAM address counter.
- oRead_Data out 4: nibble returned on reads.
- oRead_Drive out 1: responder drives DB (E high and RW=1).
- oProtocolError out 1: one-cycle pulse on any rule violation.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All outputs 0.
  - Internal increment flag ID=1, init counter 0, busy counter 0, state ST_POWERUP.
- Input registering:
  - One register stage on all bus inputs, plus a second stage for E.
  - Falling E (prev=1, now=0) is a strobe. RS/RW/Data are taken from the first-stage copy captured while E was high.
  - Rising E is a read-launch.
- ST_POWERUP (write strobe):
  - Nibble 0x3: increment init counter (saturating at 7) and load busy counter with BUSY_CYCLES.
  - Nibble 0x2 with init counter >= MIN_INIT_NIBBLES: set oFourBitMode and go to ST_HI.
  - Nibble 0x2 with fewer 0x3 nibbles, or any other nibble: pulse oProtocolError and stay in ST_POWERUP.
  - No oByteValid is produced in this state.
- ST_HI (write strobe): latch nibble as byte[7:4], latch RS, go to ST_LO.
- ST_LO (write strobe):
  - If RS differs from the latched RS: pulse oProtocolError, discard, go to ST_HI.
  - Otherwise, one cycle after the strobe cycle: oByte={hi,lo}, oIsData=RS, oCmdClass decoded, oByteValid=1. Go to ST_HI.
- oCmdClass: index of the highest set bit of the byte. 0=CLEAR (0x01), 1=HOME, 2=ENTRY, 3=DISPLAY, 4=SHIFT, 5=FUNCTION, 6=CGRAM, 7=DDRAM. Byte 0x00 gives class 0 and pulses oProtocolError. Data bytes report class 0.
- Side effects of each accepted byte:
  - CLEAR / HOME: oAddress=0 and busy counter loaded with CLEAR_BUSY_CYCLES. CLEAR also sets oInitDone.
  - ENTRY: ID=byte[1].
  - DDRAM: oAddress=byte[6:0].
  - Data write: oAddress += 1 if ID=1, else -= 1, modulo 128 (0x7F wraps to 0x00 and back).
  - All others: busy counter loaded with BUSY_CYCLES.
- Busy:
  - Busy counter decrements to 0; oBusy = (count != 0).
  - A write strobe while oBusy=1 pulses oProtocolError but is still processed.
  - A new load overrides the remaining count.
- Reads:
  - RW=1 strobes never change the write byte path.
  - In 4-bit mode they toggle ST_HI/ST_LO for phase.
  - For RS=0, on read-launch: oRead_Data = {oBusy, oAddress[6:4]} in ST_HI and oAddress[3:0] in ST_LO.
  - For RS=1: oRead_Data=0.
  - oRead_Drive=1 from the registered rising E until the registered falling E.
  - A read in ST_POWERUP pulses oProtocolError.
- Simultaneous events: a strobe and a busy decrement in the same cycle resolve as load-wins.
- Reset mid-byte discards the pending high nibble.

Decomposition:
- Package lcd_bus_pkg holds:
  - State encodings ST_POWERUP/ST_HI/ST_LO.
  - CMD_* class constants 0-7.
  - Command bit masks.
  - Nibble constants INIT_NIBBLE=0x3, MODE4_NIBBLE=0x2.
  - The same package is shared with the LCD control FSM.
- Sub-module lcd_edge_sampler: input register stages plus rise/fall pulse generation.

Test Plan:
- Power-up sequence: nibbles 3,3,3,2 -> oFourBitMode=1, no oByteValid, no error.
- Nibbles 3,2 only -> oProtocolError pulse on the 0x2, oFourBitMode stays 0.
- After init, send 2,8 / 0,C / 0,F / 0,1 (RS=0):
  - four oByteValid pulses with bytes 0x28, 0x0C, 0x0F, 0x01 and classes 5, 3, 3, 0;
  - oInitDone=1 after 0x01;
  - oBusy held 82 cycles after 0x01.
- Send DDRAM 0xFF (address 0x7F), then data 0x41 (RS=1) -> oAddress=0x00. Then ENTRY 0x04 and one data byte -> oAddress=0x7F.
- Busy read right after 0x01: RW=1, RS=0, two E pulses -> oRead_Data=0x8 then 0x0, oRead_Drive asserted only while E high. Write strobe during busy -> oProtocolError pulse.
- Send high nibble with RS=0, then low nibble with RS=1 -> oProtocolError pulse, no oByteValid. Assert Reset mid-byte -> all outputs 0, state ST_POWERUP.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD bus (controller and responder).
package lcd_bus_pkg;

  typedef enum logic [1:0] {
    ST_POWERUP = 2'd0,
    ST_HI      = 2'd1,
    ST_LO      = 2'd2
  } lcd_state_e;

  // Command class = index of the highest set bit of a command byte
  localparam logic [2:0] CMD_CLEAR    = 3'd0;
  localparam logic [2:0] CMD_HOME     = 3'd1;
  localparam logic [2:0] CMD_ENTRY    = 3'd2;
  localparam logic [2:0] CMD_DISPLAY  = 3'd3;
  localparam logic [2:0] CMD_SHIFT    = 3'd4;
  localparam logic [2:0] CMD_FUNCTION = 3'd5;
  localparam logic [2:0] CMD_CGRAM    = 3'd6;
  localparam logic [2:0] CMD_DDRAM    = 3'd7;

  // Command bit masks
  localparam logic [7:0] MASK_CLEAR    = 8'h01;
  localparam logic [7:0] MASK_ENTRY_ID = 8'h02;
  localparam logic [7:0] MASK_DDRAM    = 8'h80;
  localparam logic [7:0] MASK_DDRAM_AD = 8'h7F;

  // Power-up handshake nibbles
  localparam logic [3:0] INIT_NIBBLE  = 4'h3;
  localparam logic [3:0] MODE4_NIBBLE = 4'h2;

  // Highest set bit index; 0x00 maps to class 0
  function automatic logic [2:0] cmd_class(input logic [7:0] b);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) c = 3'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_edge_sampler.sv
// Registers the LCD bus inputs and produces E rise/fall pulses with the
// RS/RW/DB values that were present while E was high.
module lcd_edge_sampler (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [3:0] data_i,
  output logic       rise_o,
  output logic       fall_o,
  output logic       rs_now_o,
  output logic       rw_now_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [3:0] data_o
);

  logic       e1_q, e2_q;
  logic       rs1_q, rw1_q;
  logic [3:0] d1_q;
  logic       rs_h_q, rw_h_q;
  logic [3:0] d_h_q;

  // First stage on all inputs, second stage on E only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e1_q  <= 1'b0;
      e2_q  <= 1'b0;
      rs1_q <= 1'b0;
      rw1_q <= 1'b0;
      d1_q  <= '0;
    end else begin
      e1_q  <= e_i;
      e2_q  <= e1_q;
      rs1_q <= rs_i;
      rw1_q <= rw_i;
      d1_q  <= data_i;
    end
  end

  // Hold the first-stage bus copy while E is high so the falling-edge
  // strobe sees the values from the high phase, not the post-edge ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs_h_q <= 1'b0;
      rw_h_q <= 1'b0;
      d_h_q  <= '0;
    end else if (e1_q) begin
      rs_h_q <= rs1_q;
      rw_h_q <= rw1_q;
      d_h_q  <= d1_q;
    end
  end

  assign rise_o   = e1_q & ~e2_q;
  assign fall_o   = ~e1_q & e2_q;
  assign rs_now_o = rs1_q;
  assign rw_now_o = rw1_q;
  assign rs_o     = rs_h_q;
  assign rw_o     = rw_h_q;
  assign data_o   = d_h_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-side responder for the 4-bit HD44780 bus: init handshake tracking,
// nibble-pair assembly, command decode, busy/address model and busy-flag reads.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES       = 2,
  parameter int unsigned CLEAR_BUSY_CYCLES = 82,
  parameter int unsigned MIN_INIT_NIBBLES  = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oIsData,
  output logic [2:0] oCmdClass,
  output logic       oByteValid,
  output logic       oFourBitMode,
  output logic       oInitDone,
  output logic       oBusy,
  output logic [6:0] oAddress,
  output logic [3:0] oRead_Data,
  output logic       oRead_Drive,
  output logic       oProtocolError
);

  localparam int unsigned MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int unsigned BW       = $clog2(MAX_BUSY + 1);
  localparam logic [BW-1:0] LOAD_NORMAL = BW'(BUSY_CYCLES);
  localparam logic [BW-1:0] LOAD_CLEAR  = BW'(CLEAR_BUSY_CYCLES);

  logic       rise, fall, rs_now, rw_now, rs_s, rw_s;
  logic [3:0] nib_s;

  lcd_edge_sampler u_sampler (
    .clk_i    (Clock),
    .rst_ni   (Reset),
    .e_i      (iLCD_Enabled),
    .rs_i     (iLCD_RegisterSelect),
    .rw_i     (iLCD_ReadWrite),
    .data_i   (iLCD_Data),
    .rise_o   (rise),
    .fall_o   (fall),
    .rs_now_o (rs_now),
    .rw_now_o (rw_now),
    .rs_o     (rs_s),
    .rw_o     (rw_s),
    .data_o   (nib_s)
  );

  lcd_state_e    state_q, state_d;
  logic [3:0]    hi_q, hi_d;
  logic          hi_rs_q, hi_rs_d;
  logic [7:0]    byte_q, byte_d;
  logic          is_data_q, is_data_d;
  logic [2:0]    class_q, class_d;
  logic          valid_q, valid_d;
  logic          four_q, four_d;
  logic          init_done_q, init_done_d;
  logic [BW-1:0] busy_q, busy_d;
  logic [6:0]    addr_q, addr_d;
  logic          id_q, id_d;
  logic [2:0]    init_cnt_q, init_cnt_d;
  logic [3:0]    rd_data_q, rd_data_d;
  logic          rd_drive_q, rd_drive_d;
  logic          err_q, err_d;
  logic          busy_now;
  logic [7:0]    new_byte;
  logic [2:0]    new_class;

  assign busy_now  = (busy_q != '0);
  assign new_byte  = {hi_q, nib_s};
  assign new_class = cmd_class(new_byte);

  // State and model register bank
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_POWERUP;
      hi_q        <= '0;
      hi_rs_q     <= 1'b0;
      byte_q      <= '0;
      is_data_q   <= 1'b0;
      class_q     <= '0;
      valid_q     <= 1'b0;
      four_q      <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
      addr_q      <= '0;
      id_q        <= 1'b1;
      init_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_drive_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      hi_rs_q     <= hi_rs_d;
      byte_q      <= byte_d;
      is_data_q   <= is_data_d;
      class_q     <= class_d;
      valid_q     <= valid_d;
      four_q      <= four_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      init_cnt_q  <= init_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_drive_q  <= rd_drive_d;
      err_q       <= err_d;
    end
  end

  // Next-state: handshake, nibble assembly, command side effects, reads
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    hi_rs_d     = hi_rs_q;
    byte_d      = byte_q;
    is_data_d   = is_data_q;
    class_d     = class_q;
    valid_d     = 1'b0;
    four_d      = four_q;
    init_done_d = init_done_q;
    busy_d      = busy_now ? busy_q - 1'b1 : '0;
    addr_d      = addr_q;
    id_d        = id_q;
    init_cnt_d  = init_cnt_q;
    rd_data_d   = rd_data_q;
    rd_drive_d  = rd_drive_q;
    err_d       = 1'b0;

    if (rise && rw_now) begin
      rd_drive_d = 1'b1;
      if (rs_now)                rd_data_d = '0;
      else if (state_q == ST_LO) rd_data_d = addr_q[3:0];
      else                       rd_data_d = {busy_now, addr_q[6:4]};
    end

    if (fall) begin
      rd_drive_d = 1'b0;
      if (rw_s) begin
        // Reads only advance the nibble phase
        if (state_q == ST_POWERUP) err_d   = 1'b1;
        else if (state_q == ST_HI) state_d = ST_LO;
        else                       state_d = ST_HI;
      end else begin
        if (busy_now) err_d = 1'b1;
        unique case (state_q)
          ST_POWERUP: begin
            if (nib_s == INIT_NIBBLE) begin
              if (init_cnt_q != 3'd7) init_cnt_d = init_cnt_q + 3'd1;
              busy_d = LOAD_NORMAL;
            end else if (nib_s == MODE4_NIBBLE && 32'(init_cnt_q) >= MIN_INIT_NIBBLES) begin
              four_d  = 1'b1;
              state_d = ST_HI;
            end else begin
              err_d = 1'b1;
            end
          end
          ST_HI: begin
            hi_d    = nib_s;
            hi_rs_d = rs_s;
            state_d = ST_LO;
          end
          ST_LO: begin
            state_d = ST_HI;
            if (rs_s != hi_rs_q) begin
              err_d = 1'b1;
            end else begin
              byte_d    = new_byte;
              is_data_d = rs_s;
              valid_d   = 1'b1;
              busy_d    = LOAD_NORMAL;
              if (rs_s) begin
                class_d = CMD_CLEAR;
                addr_d  = id_q ? addr_q + 7'd1 : addr_q - 7'd1;
              end else begin
                class_d = new_class;
                unique case (new_class)
                  CMD_CLEAR: begin
                    if (new_byte == MASK_CLEAR) begin
                      addr_d      = '0;
                      busy_d      = LOAD_CLEAR;
                      init_done_d = 1'b1;
                    end else begin
                      err_d = 1'b1;
                    end
                  end
                  CMD_HOME: begin
                    addr_d = '0;
                    busy_d = LOAD_CLEAR;
                  end
                  CMD_ENTRY: id_d   = |(new_byte & MASK_ENTRY_ID);
                  CMD_DDRAM: addr_d = 7'(new_byte & MASK_DDRAM_AD);
                  CMD_DISPLAY, CMD_SHIFT, CMD_FUNCTION, CMD_CGRAM: ;
                  default: ;
                endcase
              end
            end
          end
          default: state_d = ST_POWERUP;
        endcase
      end
    end
  end

  assign oByte          = byte_q;
  assign oIsData        = is_data_q;
  assign oCmdClass      = class_q;
  assign oByteValid     = valid_q;
  assign oFourBitMode   = four_q;
  assign oInitDone      = init_done_q;
  assign oBusy          = busy_now;
  assign oAddress       = addr_q;
  assign oRead_Data     = rd_data_q;
  assign oRead_Drive    = rd_drive_q;
  assign oProtocolError = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: handshake, byte assembly, busy,
// address counter, busy-flag reads, protocol errors and mid-byte reset.
module tb_lcd_bus_responder;

  logic       clk;
  logic       rst_n;
  logic       e, rs, rw;
  logic [3:0] db;
  logic [7:0] oByte;
  logic       oIsData, oByteValid, oFourBitMode, oInitDone, oBusy;
  logic [2:0] oCmdClass;
  logic [6:0] oAddress;
  logic [3:0] oRead_Data;
  logic       oRead_Drive, oProtocolError;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse/event tallies kept by the monitor
  int         n_valid = 0;
  int         n_err   = 0;
  int         n_busy  = 0;
  logic [7:0] last_byte  = '0;
  logic [2:0] last_class = '0;
  logic       last_data  = 1'b0;

  int v0, e0, b0;

  lcd_bus_responder #(
    .BUSY_CYCLES       (2),
    .CLEAR_BUSY_CYCLES (82),
    .MIN_INIT_NIBBLES  (3)
  ) dut (
    .Clock               (clk),
    .Reset               (rst_n),
    .iLCD_Enabled        (e),
    .iLCD_RegisterSelect (rs),
    .iLCD_ReadWrite      (rw),
    .iLCD_Data           (db),
    .oByte               (oByte),
    .oIsData             (oIsData),
    .oCmdClass           (oCmdClass),
    .oByteValid          (oByteValid),
    .oFourBitMode        (oFourBitMode),
    .oInitDone           (oInitDone),
    .oBusy               (oBusy),
    .oAddress            (oAddress),
    .oRead_Data          (oRead_Data),
    .oRead_Drive         (oRead_Drive),
    .oProtocolError      (oProtocolError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally one-cycle pulses and busy cycles on the falling edge
  always @(negedge clk) begin
    if (oByteValid) begin
      n_valid    <= n_valid + 1;
      last_byte  <= oByte;
      last_class <= oCmdClass;
      last_data  <= oIsData;
    end
    if (oProtocolError) n_err  <= n_err + 1;
    if (oBusy)          n_busy <= n_busy + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic p_rs, input logic p_rw, input logic [3:0] d);
    @(negedge clk);
    rs = p_rs; rw = p_rw; db = d;
    @(negedge clk);
    e = 1'b1;
    repeat (3) @(negedge clk);
    e = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic p_rs, input logic [7:0] b);
    pulse(p_rs, 1'b0, b[7:4]);
    pulse(p_rs, 1'b0, b[3:0]);
  endtask

  task automatic read_pulse(input string tag, input logic [3:0] exp_nib);
    @(negedge clk);
    rs = 1'b0; rw = 1'b1;
    #1;
    check({tag, "_drive_pre"}, 32'(oRead_Drive), 32'd0);
    @(negedge clk);
    e = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_drive_hi"}, 32'(oRead_Drive), 32'd1);
    check({tag, "_data"}, 32'(oRead_Data), 32'(exp_nib));
    e = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check({tag, "_drive_post"}, 32'(oRead_Drive), 32'd0);
    rw = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {oByte, oIsData, oCmdClass, oByteValid, oFourBitMode, oInitDone,
                          oBusy, oAddress, oRead_Data, oRead_Drive, oProtocolError}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b, input logic isd,
                             input logic [2:0] cls);
    check({tag, "_valid"}, 32'(n_valid - v0), 32'd1);
    check({tag, "_byte"}, 32'(last_byte), 32'(b));
    check({tag, "_isdata"}, 32'(last_data), 32'(isd));
    check({tag, "_class"}, 32'(last_class), 32'(cls));
  endtask

  initial begin
    rst_n = 1'b0; e = 1'b0; rs = 1'b0; rw = 1'b0; db = '0;
    do_reset();

    // Short handshake: 0x2 after a single 0x3 is illegal
    e0 = n_err; v0 = n_valid;
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h2);
    check("short_init_err", 32'(n_err - e0), 32'd1);
    check("short_init_mode", 32'(oFourBitMode), 32'd0);
    check("short_init_novalid", 32'(n_valid - v0), 32'd0);

    // Full handshake 3,3,3,2
    do_reset();
    e0 = n_err; v0 = n_valid;
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h3);
    pulse(1'b0, 1'b0, 4'h2);
    check("init_mode", 32'(oFourBitMode), 32'd1);
    check("init_novalid", 32'(n_valid - v0), 32'd0);
    check("init_noerr", 32'(n_err - e0), 32'd0);

    // Configuration bytes
    e0 = n_err;
    v0 = n_valid; send_byte(1'b0, 8'h28); expect_byte("b28", 8'h28, 1'b0, 3'd5);
    v0 = n_valid; send_byte(1'b0, 8'h0C); expect_byte("b0C", 8'h0C, 1'b0, 3'd3);
    v0 = n_valid; send_byte(1'b0, 8'h0F); expect_byte("b0F", 8'h0F, 1'b0, 3'd3);
    check("initdone_before_clear", 32'(oInitDone), 32'd0);
    check("cfg_noerr", 32'(n_err - e0), 32'd0);

    // Clear Display, then busy-flag read while busy
    v0 = n_valid;
    pulse(1'b0, 1'b0, 4'h0);
    b0 = n_busy;
    pulse(1'b0, 1'b0, 4'h1);
    expect_byte("b01", 8'h01, 1'b0, 3'd0);
    check("initdone_after_clear", 32'(oInitDone), 32'd1);
    check("clear_addr", 32'(oAddress), 32'd0);
    check("clear_busy", 32'(oBusy), 32'd1);
    e0 = n_err;
    read_pulse("rd_hi", 4'h8);
    read_pulse("rd_lo", 4'h0);
    check("read_noerr", 32'(n_err - e0), 32'd0);

    // High nibble written while busy: flagged but still latched
    e0 = n_err; v0 = n_valid;
    pulse(1'b0, 1'b0, 4'h0);
    check("write_busy_err", 32'(n_err - e0), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (!oBusy) break;
      @(negedge clk);
    end
    #1;
    check("busy_released", 32'(oBusy), 32'd0);
    check("clear_busy_len", 32'(n_busy - b0), 32'd82);

    // Low nibble with different RS completes the pending byte: error, discarded
    e0 = n_err;
    pulse(1'b1, 1'b0, 4'h5);
    check("rs_mismatch_err", 32'(n_err - e0), 32'd1);
    check("rs_mismatch_novalid", 32'(n_valid - v0), 32'd0);

    // Address counter wrap both ways
    v0 = n_valid; send_byte(1'b0, 8'hFF); expect_byte("bFF", 8'hFF, 1'b0, 3'd7);
    check("ddram_addr", 32'(oAddress), 32'h7F);
    v0 = n_valid; send_byte(1'b1, 8'h41); expect_byte("d41", 8'h41, 1'b1, 3'd0);
    check("addr_wrap_up", 32'(oAddress), 32'h00);
    v0 = n_valid; send_byte(1'b0, 8'h04); expect_byte("b04", 8'h04, 1'b0, 3'd2);
    v0 = n_valid; send_byte(1'b1, 8'h42); expect_byte("d42", 8'h42, 1'b1, 3'd0);
    check("addr_wrap_down", 32'(oAddress), 32'h7F);

    // Null command byte is flagged
    e0 = n_err; v0 = n_valid;
    send_byte(1'b0, 8'h00);
    expect_byte("b00", 8'h00, 1'b0, 3'd0);
    check("null_cmd_err", 32'(n_err - e0), 32'd1);

    // Reset with a high nibble pending returns to power-up
    pulse(1'b0, 1'b0, 4'h8);
    do_reset();
    e0 = n_err;
    pulse(1'b0, 1'b0, 4'h2);
    check("post_reset_powerup_err", 32'(n_err - e0), 32'd1);
    check("post_reset_mode", 32'(oFourBitMode), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
